// File: rtl/dual_issue_pair_unit.sv
// Decode/issue stage ahead of the dual-port register file: buffers one fetched
// instruction pair, detects intra-pair hazards and issues the pair together or split over two cycles.
module dual_issue_pair_unit #(
  parameter int PC_W         = 32,
  parameter bit SPLIT_ON_WAW = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_v2,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_inst2,
  input  logic [PC_W-1:0]  in_pc,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_v2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_inst2,
  output logic [PC_W-1:0]  out_pc1,
  output logic [PC_W-1:0]  out_pc2,
  output logic [4:0]       rf_ra1_l1,
  output logic [4:0]       rf_ra2_l1,
  output logic [4:0]       rf_ra1_l2,
  output logic [4:0]       rf_ra2_l2,
  output logic [4:0]       wr_reg_l1,
  output logic [4:0]       wr_reg_l2,
  output logic             wr_en_l1,
  output logic             wr_en_l2,
  output logic [CNT_W-1:0] split_count
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  // A zero destination means "writes no register".
  function automatic logic [4:0] dest_of(input logic [31:0] inst);
    logic [4:0] d;
    case (inst[31:26])
      6'h00: begin
        if ((inst == 32'h0000_0000) || (inst[5:0] == 6'h08)) begin
          d = 5'd0;
        end else begin
          d = inst[15:11];
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: d = inst[20:16];
      6'h03:   d = 5'd31;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic reads_rs(input logic [31:0] inst);
    return !((inst[31:26] == 6'h02) || (inst[31:26] == 6'h03) || (inst[31:26] == 6'h0F));
  endfunction

  function automatic logic reads_rt(input logic [31:0] inst);
    return (inst[31:26] == 6'h00) || (inst[31:26] == 6'h04) ||
           (inst[31:26] == 6'h05) || (inst[31:26] == 6'h2B);
  endfunction

  function automatic logic is_mem(input logic [31:0] inst);
    return (inst[31:26] == 6'h23) || (inst[31:26] == 6'h2B);
  endfunction

  function automatic logic is_ctrl(input logic [31:0] inst);
    return (inst[31:26] == 6'h02) || (inst[31:26] == 6'h03) ||
           (inst[31:26] == 6'h04) || (inst[31:26] == 6'h05) ||
           ((inst[31:26] == 6'h00) && (inst[5:0] == 6'h08));
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic [31:0]       buf_inst1_r;
  logic [31:0]       buf_inst2_r;
  logic              buf_v2_r;
  logic [PC_W-1:0]   buf_pc_r;
  logic [CNT_W-1:0]  split_cnt_r;

  logic              split_s;
  logic              load_s;
  logic              cnt_inc_s;
  logic              in_ready_s;
  logic [4:0]        d1_s;
  logic [4:0]        d2_s;
  logic              lane1_v_s;
  logic              lane2_v_s;
  logic [31:0]       lane1_inst_s;
  logic [31:0]       lane2_inst_s;
  logic [PC_W-1:0]   lane1_pc_s;
  logic [PC_W-1:0]   pc_plus4_s;

  assign pc_plus4_s = buf_pc_r + PC_W'(4);

  // Intra-pair hazard detection on the buffered pair.
  always_comb begin
    d1_s    = dest_of(buf_inst1_r);
    d2_s    = dest_of(buf_inst2_r);
    split_s = 1'b0;
    if (buf_v2_r) begin
      split_s = ((d1_s != 5'd0) &&
                 ((reads_rs(buf_inst2_r) && (d1_s == buf_inst2_r[25:21])) ||
                  (reads_rt(buf_inst2_r) && (d1_s == buf_inst2_r[20:16])))) ||
                (is_mem(buf_inst1_r) && is_mem(buf_inst2_r)) ||
                is_ctrl(buf_inst1_r) ||
                (SPLIT_ON_WAW && (d1_s != 5'd0) && (d1_s == d2_s));
    end else begin
      split_s = 1'b0;
    end
  end

  // Handshake and next-state; flush overrides everything, including the accept.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    cnt_inc_s  = 1'b0;
    in_ready_s = 1'b0;
    if (flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          in_ready_s = 1'b1;
          if (in_valid) begin
            state_nx_s = ST_FULL;
            load_s     = 1'b1;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready && split_s) begin
            state_nx_s = ST_SECOND;
            cnt_inc_s  = 1'b1;
          end else if (out_ready) begin
            in_ready_s = 1'b1;
            load_s     = in_valid;
            state_nx_s = in_valid ? ST_FULL : ST_EMPTY;
          end else begin
            state_nx_s = ST_FULL;
          end
        end
        ST_SECOND: begin
          if (out_ready) begin
            in_ready_s = 1'b1;
            load_s     = in_valid;
            state_nx_s = in_valid ? ST_FULL : ST_EMPTY;
          end else begin
            state_nx_s = ST_SECOND;
          end
        end
        default: state_nx_s = ST_EMPTY;
      endcase
    end
  end

  // Lane steering: SECOND re-presents inst2 on lane 1 at pc+4.
  always_comb begin
    lane1_v_s    = 1'b0;
    lane2_v_s    = 1'b0;
    lane1_inst_s = 32'h0000_0000;
    lane2_inst_s = 32'h0000_0000;
    lane1_pc_s   = '0;
    case (state_r)
      ST_FULL: begin
        lane1_v_s    = 1'b1;
        lane1_inst_s = buf_inst1_r;
        lane1_pc_s   = buf_pc_r;
        if (buf_v2_r && !split_s) begin
          lane2_v_s    = 1'b1;
          lane2_inst_s = buf_inst2_r;
        end else begin
          lane2_v_s    = 1'b0;
        end
      end
      ST_SECOND: begin
        lane1_v_s    = 1'b1;
        lane1_inst_s = buf_inst2_r;
        lane1_pc_s   = pc_plus4_s;
      end
      default: begin
        lane1_v_s = 1'b0;
      end
    endcase
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = lane1_v_s;
  assign out_v2      = lane2_v_s;
  assign out_inst1   = lane1_inst_s;
  assign out_inst2   = lane2_inst_s;
  assign out_pc1     = lane1_pc_s;
  assign out_pc2     = lane2_v_s ? pc_plus4_s : '0;
  assign rf_ra1_l1   = lane1_inst_s[25:21];
  assign rf_ra2_l1   = lane1_inst_s[20:16];
  assign rf_ra1_l2   = lane2_inst_s[25:21];
  assign rf_ra2_l2   = lane2_inst_s[20:16];
  assign wr_reg_l1   = dest_of(lane1_inst_s);
  assign wr_reg_l2   = dest_of(lane2_inst_s);
  assign wr_en_l1    = lane1_v_s && (dest_of(lane1_inst_s) != 5'd0);
  assign wr_en_l2    = lane2_v_s && (dest_of(lane2_inst_s) != 5'd0);
  assign split_count = split_cnt_r;

  // State, pair buffer and saturating split counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      buf_inst1_r <= 32'h0000_0000;
      buf_inst2_r <= 32'h0000_0000;
      buf_v2_r    <= 1'b0;
      buf_pc_r    <= '0;
      split_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if (load_s) begin
        buf_inst1_r <= in_inst1;
        buf_inst2_r <= in_inst2;
        buf_v2_r    <= in_v2;
        buf_pc_r    <= in_pc;
      end
      if (cnt_inc_s && (split_cnt_r != {CNT_W{1'b1}})) begin
        split_cnt_r <= split_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_pair_unit.sv
// Directed bench for dual_issue_pair_unit: hand-computed expectations checked
// with immediate assertions at each step.
module tb_dual_issue_pair_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_v2;
  logic [31:0] in_inst1;
  logic [31:0] in_inst2;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_v2;
  logic [31:0] out_inst1;
  logic [31:0] out_inst2;
  logic [31:0] out_pc1;
  logic [31:0] out_pc2;
  logic [4:0]  rf_ra1_l1;
  logic [4:0]  rf_ra2_l1;
  logic [4:0]  rf_ra1_l2;
  logic [4:0]  rf_ra2_l2;
  logic [4:0]  wr_reg_l1;
  logic [4:0]  wr_reg_l2;
  logic        wr_en_l1;
  logic        wr_en_l2;
  logic [15:0] split_count;

  int checks = 0;
  int errors = 0;

  dual_issue_pair_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_v2(in_v2), .in_inst1(in_inst1), .in_inst2(in_inst2),
    .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_v2(out_v2),
    .out_inst1(out_inst1), .out_inst2(out_inst2), .out_pc1(out_pc1), .out_pc2(out_pc2),
    .rf_ra1_l1(rf_ra1_l1), .rf_ra2_l1(rf_ra2_l1), .rf_ra1_l2(rf_ra1_l2), .rf_ra2_l2(rf_ra2_l2),
    .wr_reg_l1(wr_reg_l1), .wr_reg_l2(wr_reg_l2), .wr_en_l1(wr_en_l1), .wr_en_l2(wr_en_l2),
    .split_count(split_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i1, input logic [31:0] i2, input logic v2,
                       input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst1 = i1;
    in_inst2 = i2;
    in_v2    = v2;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_v2 = 1'b0;
    in_inst1 = 32'h0; in_inst2 = 32'h0; in_pc = 32'h0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst1", out_inst1, 32'h0);
    chk("rst_split_count", {16'd0, split_count}, 32'd0);
    rst = 1'b1;
    tick();

    // non-split addi/addi pair
    offer(32'h2001_0005, 32'h2003_0007, 1'b1, 32'h100);
    tick();
    in_valid = 1'b0;
    #1;
    chk("pair_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pair_out_v2", {31'd0, out_v2}, 32'd1);
    chk("pair_wr_reg_l1", {27'd0, wr_reg_l1}, 32'd1);
    chk("pair_wr_reg_l2", {27'd0, wr_reg_l2}, 32'd3);
    chk("pair_wr_en", {30'd0, wr_en_l1, wr_en_l2}, 32'd3);
    chk("pair_pc2", out_pc2, 32'h104);
    chk("pair_in_ready", {31'd0, in_ready}, 32'd1);
    chk("pair_split_count", {16'd0, split_count}, 32'd0);
    tick();
    chk("pair_drained", {31'd0, out_valid}, 32'd0);

    // RAW pair: addi $1 ; add $2,$1,$1
    offer(32'h2001_0005, 32'h0021_1020, 1'b1, 32'h200);
    tick();
    in_valid = 1'b0;
    #1;
    chk("raw_c1_inst1", out_inst1, 32'h2001_0005);
    chk("raw_c1_v2", {31'd0, out_v2}, 32'd0);
    chk("raw_c1_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_c2_inst1", out_inst1, 32'h0021_1020);
    chk("raw_c2_pc1", out_pc1, 32'h204);
    chk("raw_c2_ra", {22'd0, rf_ra1_l1, rf_ra2_l1}, {22'd0, 5'd1, 5'd1});
    chk("raw_c2_wr_reg_l1", {27'd0, wr_reg_l1}, 32'd2);
    chk("raw_c2_v2", {31'd0, out_v2}, 32'd0);
    chk("raw_split_count", {16'd0, split_count}, 32'd1);
    tick();

    // memory pair lw/sw
    offer(32'h8C04_0000, 32'hAC05_0004, 1'b1, 32'h300);
    tick();
    in_valid = 1'b0;
    #1;
    chk("mem_c1_inst1", out_inst1, 32'h8C04_0000);
    chk("mem_c1_v2", {31'd0, out_v2}, 32'd0);
    chk("mem_c1_wr", {26'd0, wr_en_l1, wr_reg_l1}, {26'd0, 1'b1, 5'd4});
    tick();
    chk("mem_c2_inst1", out_inst1, 32'hAC05_0004);
    chk("mem_c2_wr_en", {31'd0, wr_en_l1}, 32'd0);
    chk("mem_c2_ra2", {27'd0, rf_ra2_l1}, 32'd5);
    chk("mem_split_count", {16'd0, split_count}, 32'd2);
    tick();

    // control pair beq/addi; next pair accepted out of SECOND
    offer(32'h1000_0003, 32'h2001_0005, 1'b1, 32'h400);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ctl_c1_inst1", out_inst1, 32'h1000_0003);
    chk("ctl_c1_v2", {31'd0, out_v2}, 32'd0);
    chk("ctl_c1_wr_en", {31'd0, wr_en_l1}, 32'd0);
    tick();
    chk("ctl_c2_inst1", out_inst1, 32'h2001_0005);
    chk("ctl_split_count", {16'd0, split_count}, 32'd3);
    offer(32'h2001_0005, 32'h2003_0007, 1'b1, 32'h500);
    #1;
    chk("ctl_c2_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // stall 3 cycles on a FULL non-split pair
    offer(32'h2004_000A, 32'h2005_000B, 1'b1, 32'h600);
    out_ready = 1'b0;
    #1;
    chk("stall_entry_pc1", out_pc1, 32'h500);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inst1", out_inst1, 32'h2001_0005);
      chk("stall_pc1", out_pc1, 32'h500);
      chk("stall_v2", {31'd0, out_v2}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b_inst1", out_inst1, 32'h2004_000A);
    chk("b2b_pc1", out_pc1, 32'h600);
    chk("b2b_wr_reg_l2", {27'd0, wr_reg_l2}, 32'd5);
    tick();

    // flush while FULL with a split pair: no count increment
    offer(32'h2001_0005, 32'h0021_1020, 1'b1, 32'h680);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_full_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_full_count", {16'd0, split_count}, 32'd3);

    // flush in SECOND
    offer(32'h2001_0005, 32'h0021_1020, 1'b1, 32'h700);
    tick();
    in_valid = 1'b0;
    tick();
    chk("flush_pre_inst1", out_inst1, 32'h0021_1020);
    offer(32'h2001_0005, 32'h2003_0007, 1'b1, 32'h780);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_empty_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_count", {16'd0, split_count}, 32'd4);

    // asynchronous reset mid-SECOND
    offer(32'h2001_0005, 32'h0021_1020, 1'b1, 32'h800);
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst2_pre_count", {16'd0, split_count}, 32'd5);
    #1;
    rst = 1'b0;
    #1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_out_inst1", out_inst1, 32'h0);
    chk("rst2_out_pc1", out_pc1, 32'h0);
    chk("rst2_ra1_l1", {27'd0, rf_ra1_l1}, 32'd0);
    chk("rst2_count", {16'd0, split_count}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst = 1'b1;

    // single instruction afterwards
    tick();
    offer(32'h0022_1820, 32'h2005_0001, 1'b0, 32'h900);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_v2", {31'd0, out_v2}, 32'd0);
    chk("single_wr_en_l2", {31'd0, wr_en_l2}, 32'd0);
    chk("single_inst2", out_inst2, 32'h0);
    chk("single_pc2", out_pc2, 32'h0);
    chk("single_wr_l1", {26'd0, wr_en_l1, wr_reg_l1}, {26'd0, 1'b1, 5'd3});
    tick();

    // $0 destinations: no hazard, no writes
    offer(32'h2000_0005, 32'h2000_0006, 1'b1, 32'hA00);
    tick();
    in_valid = 1'b0;
    #1;
    chk("zero_v2", {31'd0, out_v2}, 32'd1);
    chk("zero_wr_en", {30'd0, wr_en_l1, wr_en_l2}, 32'd0);
    tick();

    // WAW on $1 splits
    offer(32'h2001_0005, 32'h2001_0007, 1'b1, 32'hB00);
    tick();
    in_valid = 1'b0;
    #1;
    chk("waw_v2", {31'd0, out_v2}, 32'd0);
    tick();
    chk("waw_c2_inst1", out_inst1, 32'h2001_0007);
    chk("waw_count", {16'd0, split_count}, 32'd1);
    tick();
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
